// File: rtl/rv_alu2.sv
// Second execute stage: integer ALU, branch/jump resolution and an optional
// radix-2 restoring divider, enabled by defining RV_ALU2_DIV_EN.
module rv_alu2 #(
    parameter int IADDR_SPACE_BITS = 32
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_flush,
    input  logic [31:0]                 i_op1,
    input  logic [31:0]                 i_op2,
    input  logic [31:0]                 i_reg_data2,
    input  logic [3:0]                  i_alu_op,
    input  logic [2:0]                  i_funct3,
    input  logic [4:0]                  i_rd,
    input  logic                        i_reg_write,
    input  logic                        i_store,
    input  logic                        i_inst_jal_jalr,
    input  logic                        i_inst_branch,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
    input  logic                        i_branch_pred,
    input  logic                        i_to_trap,
    output logic [31:0]                 o_result,
    output logic [31:0]                 o_store_data,
    output logic [4:0]                  o_rd,
    output logic                        o_reg_write,
    output logic                        o_store,
    output logic [2:0]                  o_funct3,
    output logic                        o_pc_select,
    output logic [IADDR_SPACE_BITS-1:0] o_pc_target,
    output logic                        o_stall,
    output logic                        o_to_trap
);

    logic [31:0]                 alu_result;
    logic [31:0]                 link;
    logic [31:0]                 res_d;
    logic [IADDR_SPACE_BITS-1:0] target_d;
    logic                        cond;
    logic                        taken;
    logic                        pc_select_d;
    logic                        reg_write_d;
    logic                        to_trap_d;
    logic                        is_div;
    logic                        kill;
    logic [4:0]                  shamt;

    assign shamt  = i_op2[4:0];
    assign is_div = (i_alu_op[3:2] == 2'b11);
    assign link   = 32'(i_pc_next);

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        alu_result = 32'd0;
        case (i_alu_op)
            4'd0:    alu_result = i_op1 + i_op2;
            4'd1:    alu_result = i_op1 - i_op2;
            4'd2:    alu_result = i_op1 << shamt;
            4'd3:    alu_result = {31'd0, $signed(i_op1) < $signed(i_op2)};
            4'd4:    alu_result = {31'd0, i_op1 < i_op2};
            4'd5:    alu_result = i_op1 ^ i_op2;
            4'd6:    alu_result = i_op1 >> shamt;
            4'd7:    alu_result = $signed(i_op1) >>> shamt;
            4'd8:    alu_result = i_op1 | i_op2;
            4'd9:    alu_result = i_op1 & i_op2;
            4'd10:   alu_result = i_op2;
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (i_funct3)
            3'b000:  cond = (i_op1 == i_op2);
            3'b001:  cond = (i_op1 != i_op2);
            3'b100:  cond = ($signed(i_op1) < $signed(i_op2));
            3'b101:  cond = ($signed(i_op1) >= $signed(i_op2));
            3'b110:  cond = (i_op1 < i_op2);
            3'b111:  cond = (i_op1 >= i_op2);
            default: cond = 1'b0;
        endcase
    end

    assign taken       = i_inst_jal_jalr | (i_inst_branch & cond);
    assign pc_select_d = (i_inst_branch | i_inst_jal_jalr) & (taken != i_branch_pred);
    assign target_d    = taken ? {i_pc_target[IADDR_SPACE_BITS-1:1], 1'b0} : i_pc_next;

`ifdef RV_ALU2_DIV_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvsr;
    logic        neg_q;
    logic        neg_r;
    logic        op_rem;
    logic        div_signed;
    logic        div_ovf;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic [31:0] div_result;

    assign div_signed = ~i_alu_op[0];
    assign div_ovf    = div_signed & (i_op1 == 32'h8000_0000) & (i_op2 == 32'hFFFF_FFFF);
    assign op1_mag    = (div_signed & i_op1[31]) ? -i_op1 : i_op1;
    assign op2_mag    = (div_signed & i_op2[31]) ? -i_op2 : i_op2;
    assign rem_shift  = {rem, quo[31]};
    assign rem_diff   = rem_shift - {1'b0, dvsr};
    assign div_result = op_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    assign o_stall    = ~i_reset & ((state == ST_RUN) | ((state == ST_IDLE) & is_div & ~i_flush));

    // Special cases preload the final quotient/remainder with cleared sign
    // flags, so DONE applies one uniform fix-up to every outcome.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= ST_IDLE;
            cnt    <= 5'd0;
            quo    <= 32'd0;
            rem    <= 32'd0;
            dvsr   <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            op_rem <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_div && !i_flush) begin
                        op_rem <= i_alu_op[1];
                        if (i_op2 == 32'd0) begin
                            quo   <= 32'hFFFF_FFFF;
                            rem   <= i_op1;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= ST_DONE;
                        end else if (div_ovf) begin
                            quo   <= 32'h8000_0000;
                            rem   <= 32'd0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            quo   <= op1_mag;
                            dvsr  <= op2_mag;
                            rem   <= 32'd0;
                            neg_q <= div_signed & (i_op1[31] ^ i_op2[31]);
                            neg_r <= div_signed & i_op1[31];
                            cnt   <= 5'd0;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        if (!rem_diff[32]) begin
                            rem <= rem_diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= rem_shift[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign o_stall = 1'b0;
`endif

    always_comb begin
        res_d       = i_inst_jal_jalr ? link : alu_result;
        reg_write_d = i_reg_write;
        to_trap_d   = i_to_trap;
`ifdef RV_ALU2_DIV_EN
        if (state == ST_DONE) res_d = div_result;
`else
        if (is_div) begin
            reg_write_d = 1'b0;
            to_trap_d   = 1'b1;
        end
`endif
    end

    assign kill = i_flush | o_stall;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_result     <= 32'd0;
            o_store_data <= 32'd0;
            o_rd         <= 5'd0;
            o_funct3     <= 3'd0;
            o_pc_target  <= '0;
            o_reg_write  <= 1'b0;
            o_store      <= 1'b0;
            o_pc_select  <= 1'b0;
            o_to_trap    <= 1'b0;
        end else begin
            o_result     <= res_d;
            o_store_data <= i_reg_data2;
            o_rd         <= i_rd;
            o_funct3     <= i_funct3;
            o_pc_target  <= target_d;
            o_reg_write  <= reg_write_d & ~kill;
            o_store      <= i_store & ~kill;
            o_pc_select  <= pc_select_d & ~kill;
            o_to_trap    <= to_trap_d & ~kill;
        end
    end

    // The current PC is carried through the stage interface but not consumed here.
    logic unused_pc;
    assign unused_pc = ^i_pc;

endmodule

// File: doc/rv_alu2.md
# rv_alu2

Second execute stage of the FlexRV32 core, directly downstream of the operand-select stage `rv_alu1`. It consumes the resolved operands, branch target and control flags, and performs three jobs:
- computes the integer ALU result;
- resolves branches and jumps against the fetch-stage prediction, requesting a PC redirect on mispredict;
- runs an optional iterative radix-2 divider that stalls upstream for the operation's duration.

All results are registered toward the memory stage.

## Interface
Parameters:
- `IADDR_SPACE_BITS`, default 32: instruction address width.

Ports (reset is asynchronous, active-high):
- `i_clk` in 1: clock.
- `i_reset` in 1: asynchronous active-high reset.
- `i_flush` in 1: synchronous flush; kills the current op.
- `i_op1`, `i_op2` in 32: ALU operands.
- `i_reg_data2` in 32: bypassed rs2 value, used as store data.
- `i_alu_op` in 4: operation select; encoding given under Operation.
- `i_funct3` in 3: branch condition / memory size.
- `i_rd` in 5: destination register.
- `i_reg_write` in 1: op writes rd.
- `i_store` in 1: op is a store.
- `i_inst_jal_jalr` in 1: unconditional jump, including mret.
- `i_inst_branch` in 1: conditional branch.
- `i_pc`, `i_pc_next`, `i_pc_target` in `IADDR_SPACE_BITS`: current PC, fall-through PC, jump/branch target.
- `i_branch_pred` in 1: fetch predicted taken.
- `i_to_trap` in 1: op carries a trap.
- `o_result` out 32: ALU, link or divide result.
- `o_store_data` out 32: store data.
- `o_rd` out 5, `o_reg_write` out 1, `o_store` out 1, `o_funct3` out 3: forwarded control.
- `o_pc_select` out 1: redirect fetch this cycle.
- `o_pc_target` out `IADDR_SPACE_BITS`: redirect address.
- `o_stall` out 1: combinational; hold the upstream stages.
- `o_to_trap` out 1: forwarded trap, or illegal-divide trap.

## Operation
- `i_alu_op` encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS (returns `i_op2`), 11 reserved (result 0).
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
  - Shift amount is `i_op2[4:0]`.
- Branch condition, comparing `i_op1` with `i_op2`: funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; other funct3 values mean not taken.
- `taken = i_inst_jal_jalr | (i_inst_branch & cond)`.
- Jump result:
  - If `i_inst_jal_jalr`, `o_result` is `i_pc_next`, zero-extended to 32 bits.
  - Redirect target is `i_pc_target` with bit 0 cleared when taken, otherwise `i_pc_next`.
- Redirect request: `o_pc_select = (i_inst_branch | i_inst_jal_jalr) & (taken != i_branch_pred)`.
- Divider FSM:
  - IDLE: on a divide op with no flush, assert `o_stall`. If the divisor is 0 or the op is signed overflow (0x80000000 / -1), go to DONE. Otherwise latch the operand magnitudes and result signs, clear the 5-bit counter, and go to RUN.
  - RUN: one restoring shift-subtract step per cycle, with `o_stall` high. After the 32nd step (counter wraps from 31) go to DONE.
  - DONE: `o_stall` low and the output registers capture the divider result. Then return to IDLE.
- Divide special results follow RISC-V:
  - Divide by 0: quotient 0xFFFFFFFF, remainder equals the dividend.
  - Signed overflow: quotient 0x80000000, remainder 0.
  - Normal case: quotient sign is sign(op1) XOR sign(op2); remainder sign is sign(op1).
- Stall bubbles: while `o_stall` is high, the output registers load a bubble: `o_reg_write`, `o_store`, `o_pc_select` and `o_to_trap` all 0.

## Timing
- Reset: all outputs 0 and FSM in IDLE. `o_stall` is 0 while in reset.
- Non-divide ops: one-cycle latency. Every output except `o_stall` is registered.
- Normal divide:
  - `o_stall` is high for 33 cycles: the issue cycle plus 32 RUN cycles.
  - Result appears on `o_result` 34 cycles after issue, with `o_reg_write` high for one cycle.
- Divide by zero or signed overflow: `o_stall` is high for 1 cycle; the result appears 2 cycles after issue.
- `i_flush`:
  - Clears `o_reg_write`, `o_store`, `o_pc_select` and `o_to_trap` at the next edge.
  - Aborts the divider to IDLE; `o_stall` drops in the cycle after the flush.
  - Flush in the same cycle as a divide issue: flush wins and no divide starts.
- `o_pc_select` is high for exactly one cycle per mispredict. Upstream flushes in response; this block does not self-flush.

## Configuration
- `RV_ALU2_DIV_EN` defined: divider and FSM are present, as described above.
- Undefined: no divider state. `o_stall` is tied to 0. Ops 12–15 register `o_result = 0`, `o_reg_write = 0` and `o_to_trap = 1` with one-cycle latency.

## Test plan
- ADD 0x7FFFFFFF + 1, rd=5 -> next cycle `o_result` = 0x80000000, `o_rd` = 5, `o_reg_write` = 1.
- BLT with op1 = -1, op2 = 1, predicted not-taken, `i_pc_target` = 0x100 -> `o_pc_select` = 1, `o_pc_target` = 0x100, for one cycle. The same branch predicted taken -> `o_pc_select` = 0.
- JALR with `i_pc_target` = 0x203, `i_pc_next` = 0x44 -> `o_pc_target` = 0x202, `o_result` = 0x44.
- DIV -7 / 2 -> `o_stall` high for 33 cycles, then `o_result` = 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF.
- DIVU 5 / 0 -> 1 stall cycle, then `o_result` = 0xFFFFFFFF. REM 0x80000000 / -1 -> `o_result` = 0.
- Start a DIV, then assert `i_flush` in RUN cycle 10 -> `o_stall` is 0 from the next cycle and no result is written. The following ADD completes with one-cycle latency.
